// File: rtl/aes_pkg.sv
// Shared AES definitions: reduction polynomial, xtime, datapath widths, FSM states.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int         STATE_W  = 128;
  localparam int         COL_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  // Multiply by x in GF(2^8) mod 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/inv_cal_word.sv
// Combinational InvMixColumns on one 32-bit column; byte 0 is the MSB.
module inv_cal_word
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  logic [7:0] s [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  // Each constant is a sum of x8, x4, x2 and x terms built from chained xtime
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      logic [7:0] x2, x4, x8;
      s[i]  = col_i[COL_W-1-8*i -: 8];
      x2    = xtime(s[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ s[i];
      mb[i] = x8 ^ x2 ^ s[i];
      md[i] = x8 ^ x4 ^ s[i];
      me[i] = x8 ^ x4 ^ x2;
    end
  end

  assign col_o[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
  assign col_o[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
  assign col_o[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
  assign col_o[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];

endmodule

// File: rtl/inv_mix_column_iter.sv
// Iterative InvMixColumns: accepts a 128-bit state, transforms one column per
// cycle through a shared inv_cal_word, and holds the result under valid/ready.
module inv_mix_column_iter
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
);

  fsm_state_e         state_q;
  logic [1:0]         col_idx_q;
  logic [STATE_W-1:0] work_q;
  logic [STATE_W-1:0] work_d;
  logic               out_valid_q;
  logic [COL_W-1:0]   col_in;
  logic [COL_W-1:0]   col_out;

  always_comb begin
    col_in = work_q[127:96];
    case (col_idx_q)
      2'd1:    col_in = work_q[95:64];
      2'd2:    col_in = work_q[63:32];
      2'd3:    col_in = work_q[31:0];
      default: col_in = work_q[127:96];
    endcase
  end

  inv_cal_word u_inv_cal_word (
    .col_i (col_in),
    .col_o (col_out)
  );

  always_comb begin
    work_d = work_q;
    case (col_idx_q)
      2'd0:    work_d[127:96] = col_out;
      2'd1:    work_d[95:64]  = col_out;
      2'd2:    work_d[63:32]  = col_out;
      default: work_d[31:0]   = col_out;
    endcase
  end

  // DONE with out_ready doubles as an accept slot for back-to-back states
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = work_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_idx_q   <= 2'd0;
      work_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            work_q    <= in_data;
            col_idx_q <= 2'd0;
            state_q   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          work_q    <= work_d;
          col_idx_q <= col_idx_q + 2'd1;
          if (col_idx_q == 2'd3) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              work_q    <= in_data;
              col_idx_q <= 2'd0;
              state_q   <= ST_BUSY;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_column_iter.sv
// Self-checking bench for inv_mix_column_iter using a scoreboard queue of expected states.
module tb_inv_mix_column_iter;

  localparam int MAXW = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] sb[$];

  always #5 clk = ~clk;

  inv_mix_column_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  function automatic logic [7:0] m2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Forward MixColumns reference, used to build round-trip stimulus
  function automatic logic [127:0] fwd_mix(input logic [127:0] st);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = st[127-32*c -: 8];
      a1 = st[119-32*c -: 8];
      a2 = st[111-32*c -: 8];
      a3 = st[103-32*c -: 8];
      r[127-32*c -: 8] = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
      r[103-32*c -: 8] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < MAXW) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step(); step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++;
    if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data got=%h want=0", out_data); end
  endtask

  task automatic test_known_vectors();
    logic [127:0] vin [2];
    logic [127:0] vexp[2];
    logic [127:0] exp;
    int cyc;
    vin[0]  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    vexp[0] = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    vin[1]  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    vexp[1] = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL kv%0d_in_ready got=%b want=1", k, in_ready); end
      in_valid = 1'b1; in_data = vin[k]; sb.push_back(vexp[k]);
      step();
      in_valid = 1'b0; in_data = rand128();
      wait_valid(cyc);
      n_checks++;
      if (cyc !== 4) begin n_fail++; $display("FAIL kv%0d_latency got=%0d want=4", k, cyc); end
      exp = sb.pop_front();
      n_checks++;
      if (out_data !== exp) begin n_fail++; $display("FAIL kv%0d_data got=%h want=%h", k, out_data, exp); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL kv%0d_consumed got=%b want=0", k, out_valid); end
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] x, exp;
    int cyc;
    for (int k = 0; k < 1000; k++) begin
      x = rand128();
      sb.push_back(x);
      in_valid = 1'b1; in_data = fwd_mix(x);
      step();
      in_valid = 1'b0;
      wait_valid(cyc);
      exp = sb.pop_front();
      n_checks++;
      if (cyc >= MAXW || out_data !== exp) begin
        n_fail++;
        $display("FAIL round_trip_%0d got=%h want=%h cycles=%0d", k, out_data, exp, cyc);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] exp, x2;
    int cyc;
    int bad = 0;
    sb.push_back(128'hdb135345_f20a225c_01010101_c6c6c6c6);
    in_valid = 1'b1; in_data = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    step();
    in_valid = 1'b0;
    wait_valid(cyc);
    exp = sb.pop_front();
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0]; in_data = rand128();
      #1;
      if (out_data !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold_%0d data=%h want=%h in_ready=%b out_valid=%b", k, out_data, exp, in_ready, out_valid);
      end
      step();
    end
    n_checks++;
    if (bad != 0) n_fail++;
    n_checks++;
    if (out_data !== exp) begin n_fail++; $display("FAIL bp_after_hold got=%h want=%h", out_data, exp); end
    x2 = rand128();
    sb.push_back(x2);
    in_valid = 1'b1; in_data = fwd_mix(x2); out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_reaccept out_valid=%b in_ready=%b want=0,0", out_valid, in_ready);
    end
    wait_valid(cyc);
    exp = sb.pop_front();
    n_checks++;
    if (cyc !== 4 || out_data !== exp) begin
      n_fail++; $display("FAIL bp_second got=%h want=%h cycles=%0d", out_data, exp, cyc);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] src[8];
    logic [127:0] exp;
    int sent = 0, recv = 0, cyc = 0, last = -1;
    logic acc, cons;
    for (int k = 0; k < 8; k++) src[k] = rand128();
    out_ready = 1'b1; in_valid = 1'b1; in_data = fwd_mix(src[0]);
    while (recv < 8 && cyc < 200) begin
      #1;
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons) begin
        exp = sb.pop_front();
        n_checks++;
        if (out_data !== exp) begin n_fail++; $display("FAIL stream_data_%0d got=%h want=%h", recv, out_data, exp); end
        if (last >= 0) begin
          n_checks++;
          if (cyc - last != 5) begin n_fail++; $display("FAIL stream_spacing_%0d got=%0d want=5", recv, cyc - last); end
        end
        last = cyc;
        recv++;
      end
      if (acc) sb.push_back(src[sent]);
      step();
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 8) in_data = fwd_mix(src[sent]);
        else in_valid = 1'b0;
      end
    end
    n_checks++;
    if (recv != 8 || sent != 8 || sb.size() != 0) begin
      n_fail++; $display("FAIL stream_count recv=%0d sent=%0d left=%0d want=8,8,0", recv, sent, sb.size());
    end
    out_ready = 1'b0; in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic [127:0] exp;
    int cyc;
    in_valid = 1'b1; in_data = rand128();
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_mid out_valid=%b in_ready=%b data=%h want=0,1,0", out_valid, in_ready, out_data);
    end
    rst = 1'b0;
    sb.delete();
    sb.push_back(128'hd4d4d4d5_2d26314c_00000000_ffffffff);
    in_valid = 1'b1; in_data = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    step();
    in_valid = 1'b0;
    wait_valid(cyc);
    exp = sb.pop_front();
    n_checks++;
    if (cyc !== 4 || out_data !== exp) begin
      n_fail++; $display("FAIL reset_mid_fresh got=%h want=%h cycles=%0d", out_data, exp, cyc);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_round_trip();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
